univ_shift_reg: RTL

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_reg_pkg.sv | 28 ++
 rtl/univ_shift_reg_shift_counter.sv | 58 +++++
 rtl/univ_shift_reg.sv | 92 +++++++++
 3 files changed

// File: rtl/univ_shift_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : univ_shift_reg_pkg
// Purpose  : Shared definitions for the universal shift register: operation
//            mode encodings and the shift-counter width helper. Imported by
//            the RTL and by the testbench so both agree on the encodings.
// Revision : 1.0 - initial release
// ============================================================================
package univ_shift_reg_pkg;

    // Operation select encodings for the 2-bit mode input.
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Bits needed to represent values 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    // True for the two shifting modes (either direction).
    function automatic logic is_shift(input logic [1:0] mode);
        return (mode == MODE_SHR) || (mode == MODE_SHL);
    endfunction

endpackage : univ_shift_reg_pkg
`default_nettype wire

// File: rtl/univ_shift_reg_shift_counter.sv
`default_nettype none
// ============================================================================
// Module   : shift_counter
// Purpose  : Counts enabled shifts (both directions together) since the last
//            load or reset and emits a registered one-cycle pulse when WIDTH
//            shifts have accumulated, wrapping the count back to zero.
// Ports    : clk      - clock, rising edge
//            rst_n    - asynchronous active-low reset
//            i_en     - clock enable; 0 freezes the count, pulse drops
//            i_shift  - current operation is a shift (either direction)
//            i_load   - current operation is a parallel load (clears count)
//            o_done   - one-cycle pulse following the WIDTH-th shift
// Revision : 1.0 - initial release
// ============================================================================
module shift_counter
    import univ_shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_shift,
    input  logic i_load,
    output logic o_done
);

    localparam int            CW     = cnt_width(WIDTH);
    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    logic [CW-1:0] r_cnt;
    logic          r_done;
    logic          w_wrap;

    // The shift that would take the count to WIDTH wraps it to 0 instead;
    // that same condition, registered, is the completion pulse.
    assign w_wrap = i_en && i_shift && (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_wrap;
            if (i_en) begin
                if (i_load) begin
                    r_cnt <= '0;
                end else if (i_shift) begin
                    r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
                end
            end
        end
    end

    assign o_done = r_done;

endmodule : shift_counter
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : univ_shift_reg
// Purpose  : WIDTH-bit universal shift register: hold, shift right, shift
//            left and parallel load, with clock enable, serial taps and a
//            completion pulse every WIDTH shifts since the last load/reset.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset (Q <= RESET_VAL)
//            en         - clock enable; 0 freezes all state
//            mode       - 00 hold, 01 shift right, 10 shift left, 11 load
//            sin_r      - serial bit entering at the MSB on a right shift
//            sin_l      - serial bit entering at the LSB on a left shift
//            D          - parallel load data
//            Q          - registered contents
//            sout_r     - Q[0], the bit leaving on a right shift
//            sout_l     - Q[WIDTH-1], the bit leaving on a left shift
//            shift_done - one-cycle pulse after every WIDTH-th shift
// Notes    : WIDTH legal range is 1..64.
// Revision : 1.0 - initial release
// ============================================================================
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             shift_done
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_next;

    // A 1-bit register has no neighbours to shift in from, so both shift
    // directions degenerate into loading the serial input.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_shr = sin_r;
            assign w_shl = sin_l;
        end else begin : g_wn
            assign w_shr = {sin_r, r_q[WIDTH-1:1]};
            assign w_shl = {r_q[WIDTH-2:0], sin_l};
        end
    endgenerate

    // 4:1 next-state mux.
    always_comb begin
        w_next = r_q;
        case (mode)
            MODE_SHR:  w_next = w_shr;
            MODE_SHL:  w_next = w_shl;
            MODE_LOAD: w_next = D;
            default:   w_next = r_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= RESET_VAL;
        end else if (en) begin
            r_q <= w_next;
        end
    end

    shift_counter #(
        .WIDTH (WIDTH)
    ) u_shift_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (en),
        .i_shift (is_shift(mode)),
        .i_load  (mode == MODE_LOAD),
        .o_done  (shift_done)
    );

    assign Q      = r_q;
    assign sout_r = r_q[0];
    assign sout_l = r_q[WIDTH-1];

endmodule : univ_shift_reg
`default_nettype wire
